// File: rtl/lsf_engine_scheduler.sv
// lsf_engine_scheduler
// Hands each incoming ROI word to a free Legendre segment-finder engine in
// round-robin order, steers that ROI's MDT hit train to the chosen engine,
// closes the event with a one-cycle eof pulse and tracks per-engine busy
// state until the engine reports its result. ROIs that find every engine
// busy are dropped and counted.
// Optional feature: define LSF_SCHED_TIMEOUT_EN to add a per-engine busy
// watchdog (TIMEOUT cycles) that frees a stuck engine and raises the sticky
// err_timeout flag. Without it err_timeout is tied low.
module lsf_engine_scheduler #(
  parameter int NUM_ENGINES = 3,
  parameter int ROI_W       = 64,
  parameter int HIT_W       = 32,
  parameter int MAX_HITS    = 32,
  parameter int TIMEOUT     = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [ROI_W-1:0]       roi,
  input  logic                   roi_we,
  input  logic [HIT_W-1:0]       mdt_hit,
  input  logic                   mdt_hit_we,
  input  logic                   hits_last,
  input  logic [NUM_ENGINES-1:0] eng_done,
  output logic [ROI_W-1:0]       eng_roi,
  output logic [NUM_ENGINES-1:0] eng_roi_we,
  output logic [HIT_W-1:0]       eng_hit,
  output logic [NUM_ENGINES-1:0] eng_hit_we,
  output logic [NUM_ENGINES-1:0] eng_eof,
  output logic [NUM_ENGINES-1:0] eng_busy,
  output logic                   roi_drop,
  output logic [15:0]            drop_count,
  output logic                   err_timeout
);

  localparam int SEL_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam int CNT_W = $clog2(MAX_HITS + 1);

  if (NUM_ENGINES < 1 || NUM_ENGINES > 8) begin : g_bad_num_engines
    $error("lsf_engine_scheduler: NUM_ENGINES must be in 1..8");
  end
  if (MAX_HITS < 1 || TIMEOUT < 1) begin : g_bad_limits
    $error("lsf_engine_scheduler: MAX_HITS and TIMEOUT must be positive");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STREAM  = 2'd1,
    CLOSE   = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t                 state, state_n;
  logic [SEL_W-1:0]       ptr, ptr_n;
  logic [SEL_W-1:0]       sel, sel_n;
  logic [CNT_W-1:0]       hit_cnt, hit_cnt_n;
  logic                   close_discard, close_discard_n;
  logic                   pend_vld, pend_vld_n;
  logic [ROI_W-1:0]       pend_roi, pend_roi_n;
  logic [NUM_ENGINES-1:0] busy_n;
  logic [NUM_ENGINES-1:0] busy_kept;
  logic [NUM_ENGINES-1:0] free;
  logic [NUM_ENGINES-1:0] expire;
  logic                   found;
  logic [SEL_W-1:0]       win;
  logic                   drop_inc;
  logic [ROI_W-1:0]       eng_roi_d;
  logic [NUM_ENGINES-1:0] eng_roi_we_d;
  logic [HIT_W-1:0]       eng_hit_d;
  logic [NUM_ENGINES-1:0] eng_hit_we_d;
  logic [NUM_ENGINES-1:0] eng_eof_d;

`ifdef LSF_SCHED_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TO_W-1:0] to_cnt [NUM_ENGINES];
  logic            err_q;

  // An engine whose busy time reaches TIMEOUT cycles is treated as finished
  always_comb begin
    expire = '0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      expire[i] = eng_busy[i] && (to_cnt[i] == TO_W'(TIMEOUT - 1));
    end
  end

  // Per-engine busy watchdog counters and the sticky timeout flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENGINES; i++) begin
        to_cnt[i] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ENGINES; i++) begin
        if (!eng_busy[i] || eng_done[i] || expire[i]) begin
          to_cnt[i] <= '0;
        end else begin
          to_cnt[i] <= to_cnt[i] + 1'b1;
        end
      end
      if (|(expire & ~eng_done)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_timeout = err_q;
`else
  assign expire      = '0;
  assign err_timeout = 1'b0;
`endif

  // Engines released this cycle (done or watchdog) count as free right away
  assign busy_kept = eng_busy & ~eng_done & ~expire;
  assign free      = ~busy_kept;

  // Round-robin search for the first free engine starting at the pointer
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_ENGINES; k++) begin
      if (!found && free[(int'(ptr) + k) % NUM_ENGINES]) begin
        found = 1'b1;
        win   = SEL_W'((int'(ptr) + k) % NUM_ENGINES);
      end
    end
  end

  // Next-state, bookkeeping and registered-output staging for the event FSM
  always_comb begin
    state_n         = state;
    ptr_n           = ptr;
    sel_n           = sel;
    hit_cnt_n       = hit_cnt;
    close_discard_n = close_discard;
    pend_vld_n      = pend_vld;
    pend_roi_n      = pend_roi;
    busy_n          = busy_kept;
    drop_inc        = 1'b0;
    eng_roi_d       = eng_roi;
    eng_roi_we_d    = '0;
    eng_hit_d       = eng_hit;
    eng_hit_we_d    = '0;
    eng_eof_d       = '0;

    case (state)
      IDLE: begin
        // A parked ROI is serviced first; a fresh roi_we then takes its slot
        if (pend_vld || roi_we) begin
          if (pend_vld) begin
            pend_vld_n = roi_we;
            if (roi_we) begin
              pend_roi_n = roi;
            end
          end
          if (found) begin
            sel_n              = win;
            ptr_n              = (win == SEL_W'(NUM_ENGINES - 1)) ? '0 : win + 1'b1;
            busy_n[win]        = 1'b1;
            eng_roi_we_d[win]  = 1'b1;
            eng_roi_d          = pend_vld ? pend_roi : roi;
            hit_cnt_n          = '0;
            close_discard_n    = 1'b0;
            state_n            = STREAM;
          end else begin
            drop_inc = 1'b1;
            state_n  = DISCARD;
          end
        end
      end

      STREAM: begin
        if (mdt_hit_we) begin
          eng_hit_we_d[sel] = 1'b1;
          eng_hit_d         = mdt_hit;
          hit_cnt_n         = hit_cnt + 1'b1;
        end
        if (roi_we) begin
          state_n         = CLOSE;
          close_discard_n = 1'b0;
        end else if (mdt_hit_we) begin
          if (hits_last) begin
            state_n         = CLOSE;
            close_discard_n = 1'b0;
          end else if (hit_cnt == CNT_W'(MAX_HITS - 1)) begin
            state_n         = CLOSE;
            close_discard_n = 1'b1;
          end
        end
      end

      CLOSE: begin
        eng_eof_d[sel] = 1'b1;
        if (close_discard && !(mdt_hit_we && hits_last)) begin
          state_n = DISCARD;
        end else begin
          state_n = IDLE;
        end
      end

      DISCARD: begin
        if (mdt_hit_we && hits_last) begin
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    // Outside IDLE a new ROI waits in the one-deep pending slot, or is dropped
    if (state != IDLE && roi_we) begin
      if (pend_vld) begin
        drop_inc = 1'b1;
      end else begin
        pend_vld_n = 1'b1;
        pend_roi_n = roi;
      end
    end
  end

  // State, pointer, busy flags, drop counter and all registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      ptr           <= '0;
      sel           <= '0;
      hit_cnt       <= '0;
      close_discard <= 1'b0;
      pend_vld      <= 1'b0;
      pend_roi      <= '0;
      eng_busy      <= '0;
      eng_roi       <= '0;
      eng_roi_we    <= '0;
      eng_hit       <= '0;
      eng_hit_we    <= '0;
      eng_eof       <= '0;
      roi_drop      <= 1'b0;
      drop_count    <= '0;
    end else begin
      state         <= state_n;
      ptr           <= ptr_n;
      sel           <= sel_n;
      hit_cnt       <= hit_cnt_n;
      close_discard <= close_discard_n;
      pend_vld      <= pend_vld_n;
      pend_roi      <= pend_roi_n;
      eng_busy      <= busy_n;
      eng_roi       <= eng_roi_d;
      eng_roi_we    <= eng_roi_we_d;
      eng_hit       <= eng_hit_d;
      eng_hit_we    <= eng_hit_we_d;
      eng_eof       <= eng_eof_d;
      roi_drop      <= drop_inc;
      if (drop_inc && drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_lsf_engine_scheduler.sv
// tb_lsf_engine_scheduler
// Drives ROI/hit trains into a 3-engine scheduler. Each scenario pushes the
// strobes it expects (ROI writes, hit writes, eofs, drops) onto a queue; a
// negedge monitor pops and compares every strobe the DUT emits.
module tb_lsf_engine_scheduler;

  localparam int N    = 3;
  localparam int RW   = 16;
  localparam int HW   = 16;
  localparam int MAXH = 32;
  localparam int TO   = 1024;

  localparam logic [1:0] EV_DROP = 2'd0;
  localparam logic [1:0] EV_ROI  = 2'd1;
  localparam logic [1:0] EV_HIT  = 2'd2;
  localparam logic [1:0] EV_EOF  = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [2:0]  eng;
    logic [15:0] data;
  } ev_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [RW-1:0] roi = '0;
  logic          roi_we = 1'b0;
  logic [HW-1:0] mdt_hit = '0;
  logic          mdt_hit_we = 1'b0;
  logic          hits_last = 1'b0;
  logic [N-1:0]  eng_done = '0;
  logic [RW-1:0] eng_roi;
  logic [N-1:0]  eng_roi_we;
  logic [HW-1:0] eng_hit;
  logic [N-1:0]  eng_hit_we;
  logic [N-1:0]  eng_eof;
  logic [N-1:0]  eng_busy;
  logic          roi_drop;
  logic [15:0]   drop_count;
  logic          err_timeout;

  int  checks   = 0;
  int  failures = 0;
  ev_t exp_q[$];
  ev_t obs [4];
  int  n_obs;
  ev_t exp_e;

  lsf_engine_scheduler #(
    .NUM_ENGINES(N),
    .ROI_W(RW),
    .HIT_W(HW),
    .MAX_HITS(MAXH),
    .TIMEOUT(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .roi(roi),
    .roi_we(roi_we),
    .mdt_hit(mdt_hit),
    .mdt_hit_we(mdt_hit_we),
    .hits_last(hits_last),
    .eng_done(eng_done),
    .eng_roi(eng_roi),
    .eng_roi_we(eng_roi_we),
    .eng_hit(eng_hit),
    .eng_hit_we(eng_hit_we),
    .eng_eof(eng_eof),
    .eng_busy(eng_busy),
    .roi_drop(roi_drop),
    .drop_count(drop_count),
    .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  function automatic void push(input logic [1:0] kind, input logic [2:0] eng, input logic [15:0] data);
    ev_t e;
    e.kind = kind;
    e.eng  = eng;
    e.data = data;
    exp_q.push_back(e);
  endfunction

  // Scoreboard monitor: every emitted strobe must match the next expected event
  always @(negedge clock) begin
    if (!reset) begin
      n_obs = 0;
      if (roi_drop) begin
        obs[n_obs] = '{kind: EV_DROP, eng: 3'b000, data: 16'h0000};
        n_obs++;
      end
      if (|eng_roi_we) begin
        obs[n_obs] = '{kind: EV_ROI, eng: eng_roi_we, data: eng_roi};
        n_obs++;
      end
      if (|eng_hit_we) begin
        obs[n_obs] = '{kind: EV_HIT, eng: eng_hit_we, data: eng_hit};
        n_obs++;
      end
      if (|eng_eof) begin
        obs[n_obs] = '{kind: EV_EOF, eng: eng_eof, data: 16'h0000};
        n_obs++;
      end
      for (int i = 0; i < n_obs; i++) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_event got kind=%0d eng=%b data=%h expected none",
                   obs[i].kind, obs[i].eng, obs[i].data);
        end else begin
          exp_e = exp_q.pop_front();
          if (obs[i] !== exp_e) begin
            failures++;
            $display("[TB] FAIL scoreboard_event got kind=%0d eng=%b data=%h expected kind=%0d eng=%b data=%h",
                     obs[i].kind, obs[i].eng, obs[i].data, exp_e.kind, exp_e.eng, exp_e.data);
          end
        end
      end
    end
  end

  task automatic drive(input logic rw, input logic [15:0] r, input logic hw,
                       input logic [15:0] h, input logic last, input logic [2:0] done);
    @(negedge clock);
    roi_we     = rw;
    roi        = r;
    mdt_hit_we = hw;
    mdt_hit    = h;
    hits_last  = last;
    eng_done   = done;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 3'b000);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (eng_roi_we !== 3'b000 || eng_hit_we !== 3'b000 || eng_eof !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_strobes got roi_we=%b hit_we=%b eof=%b expected 000", eng_roi_we, eng_hit_we, eng_eof);
    end
    checks++;
    if (eng_busy !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_busy got %b expected 000", eng_busy);
    end
    checks++;
    if (drop_count !== 16'd0 || roi_drop !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_drop got count=%0d pulse=%b expected 0/0", drop_count, roi_drop);
    end
    checks++;
    if (eng_roi !== 16'h0 || eng_hit !== 16'h0 || err_timeout !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_data got roi=%h hit=%h err=%b expected 0", eng_roi, eng_hit, err_timeout);
    end
    reset = 1'b0;
    idle(2);
  endtask

  // Three ROIs with four hits each land on engines 0, 1, 2
  task automatic test_basic();
    for (int i = 0; i < 3; i++) begin
      push(EV_ROI, 3'(1 << i), 16'hA000 + 16'(i));
      for (int j = 0; j < 4; j++) push(EV_HIT, 3'(1 << i), 16'h1000 + 16'(i * 16 + j));
      push(EV_EOF, 3'(1 << i), 16'h0);
      drive(1'b1, 16'hA000 + 16'(i), 1'b0, 16'h0, 1'b0, 3'b000);
      for (int j = 0; j < 4; j++) begin
        drive(1'b0, 16'h0, 1'b1, 16'h1000 + 16'(i * 16 + j), (j == 3), 3'b000);
        if (j == 0) begin
          checks++;
          if (eng_roi_we !== 3'(1 << i) || eng_roi !== 16'hA000 + 16'(i)) begin
            failures++;
            $display("[TB] FAIL basic_roi_latency got we=%b roi=%h expected we=%b roi=%h",
                     eng_roi_we, eng_roi, 3'(1 << i), 16'hA000 + 16'(i));
          end
        end
      end
      idle(2);
    end
    checks++;
    if (eng_busy !== 3'b111) begin
      failures++;
      $display("[TB] FAIL basic_busy got %b expected 111", eng_busy);
    end
    checks++;
    if (drop_count !== 16'd0) begin
      failures++;
      $display("[TB] FAIL basic_drop_count got %0d expected 0", drop_count);
    end
  endtask

  // Fourth ROI with every engine busy is dropped and its hits swallowed
  task automatic test_drop();
    push(EV_DROP, 3'b000, 16'h0);
    drive(1'b1, 16'hB000, 1'b0, 16'h0, 1'b0, 3'b000);
    for (int j = 0; j < 4; j++) begin
      drive(1'b0, 16'h0, 1'b1, 16'h1100 + 16'(j), (j == 3), 3'b000);
      if (j == 0) begin
        checks++;
        if (roi_drop !== 1'b1) begin
          failures++;
          $display("[TB] FAIL drop_pulse got %b expected 1", roi_drop);
        end
      end
    end
    idle(2);
    checks++;
    if (drop_count !== 16'd1) begin
      failures++;
      $display("[TB] FAIL drop_count got %0d expected 1", drop_count);
    end
    checks++;
    if (eng_busy !== 3'b111) begin
      failures++;
      $display("[TB] FAIL drop_busy got %b expected 111", eng_busy);
    end
  endtask

  // Engine 1 finishing in the same cycle as a new ROI is reused immediately
  task automatic test_done_same_cycle();
    push(EV_ROI, 3'b010, 16'hC001);
    push(EV_HIT, 3'b010, 16'h4000);
    push(EV_HIT, 3'b010, 16'h4001);
    push(EV_EOF, 3'b010, 16'h0);
    drive(1'b1, 16'hC001, 1'b0, 16'h0, 1'b0, 3'b010);
    drive(1'b0, 16'h0, 1'b1, 16'h4000, 1'b0, 3'b000);
    checks++;
    if (eng_roi_we !== 3'b010 || eng_busy !== 3'b111) begin
      failures++;
      $display("[TB] FAIL done_reassign got we=%b busy=%b expected 010/111", eng_roi_we, eng_busy);
    end
    drive(1'b0, 16'h0, 1'b1, 16'h4001, 1'b1, 3'b000);
    idle(2);
  endtask

  // Freeing engines 0 and 2 proves the pointer sits at 2; then the 32-hit cap
  task automatic test_cap();
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 3'b101);
    idle(1);
    checks++;
    if (eng_busy !== 3'b010) begin
      failures++;
      $display("[TB] FAIL cap_busy_after_done got %b expected 010", eng_busy);
    end
    push(EV_ROI, 3'b100, 16'hD000);
    for (int j = 0; j < MAXH; j++) push(EV_HIT, 3'b100, 16'h2000 + 16'(j));
    push(EV_EOF, 3'b100, 16'h0);
    drive(1'b1, 16'hD000, 1'b0, 16'h0, 1'b0, 3'b000);
    for (int j = 0; j < 40; j++) begin
      drive(1'b0, 16'h0, 1'b1, 16'h2000 + 16'(j), (j == 39), 3'b000);
      if (j == 33) begin
        checks++;
        if (eng_eof !== 3'b100) begin
          failures++;
          $display("[TB] FAIL cap_eof_timing got %b expected 100", eng_eof);
        end
      end
      if (j == 35) begin
        checks++;
        if (eng_hit_we !== 3'b000) begin
          failures++;
          $display("[TB] FAIL cap_swallow got %b expected 000", eng_hit_we);
        end
      end
    end
    idle(2);
    checks++;
    if (eng_busy !== 3'b110) begin
      failures++;
      $display("[TB] FAIL cap_busy got %b expected 110", eng_busy);
    end
  endtask

  // New ROI mid-stream closes the current event and is serviced two cycles on
  task automatic test_roi_in_stream();
    push(EV_ROI, 3'b001, 16'hE000);
    push(EV_HIT, 3'b001, 16'h3000);
    push(EV_HIT, 3'b001, 16'h3001);
    push(EV_DROP, 3'b000, 16'h0);
    push(EV_EOF, 3'b001, 16'h0);
    push(EV_ROI, 3'b010, 16'hE001);
    for (int j = 0; j < 3; j++) push(EV_HIT, 3'b010, 16'h3100 + 16'(j));
    push(EV_EOF, 3'b010, 16'h0);
    drive(1'b1, 16'hE000, 1'b0, 16'h0, 1'b0, 3'b000);
    drive(1'b0, 16'h0, 1'b1, 16'h3000, 1'b0, 3'b000);
    drive(1'b0, 16'h0, 1'b1, 16'h3001, 1'b0, 3'b000);
    drive(1'b1, 16'hE001, 1'b0, 16'h0, 1'b0, 3'b010);
    drive(1'b1, 16'hE002, 1'b0, 16'h0, 1'b0, 3'b000);
    checks++;
    if (eng_eof !== 3'b000) begin
      failures++;
      $display("[TB] FAIL stream_eof_early got %b expected 000", eng_eof);
    end
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 3'b000);
    checks++;
    if (eng_eof !== 3'b001 || roi_drop !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stream_eof got eof=%b drop=%b expected 001/1", eng_eof, roi_drop);
    end
    drive(1'b0, 16'h0, 1'b1, 16'h3100, 1'b0, 3'b000);
    checks++;
    if (eng_roi_we !== 3'b010 || eng_roi !== 16'hE001) begin
      failures++;
      $display("[TB] FAIL stream_pending got we=%b roi=%h expected 010/e001", eng_roi_we, eng_roi);
    end
    drive(1'b0, 16'h0, 1'b1, 16'h3101, 1'b0, 3'b000);
    drive(1'b0, 16'h0, 1'b1, 16'h3102, 1'b1, 3'b000);
    idle(3);
    checks++;
    if (drop_count !== 16'd2 || eng_busy !== 3'b111) begin
      failures++;
      $display("[TB] FAIL stream_final got count=%0d busy=%b expected 2/111", drop_count, eng_busy);
    end
  endtask

  // Long wait with no done: watchdog behaviour depends on the build option
  task automatic test_timeout();
    idle(TO + 100);
`ifdef LSF_SCHED_TIMEOUT_EN
    checks++;
    if (eng_busy !== 3'b000) begin
      failures++;
      $display("[TB] FAIL timeout_busy got %b expected 000", eng_busy);
    end
    checks++;
    if (err_timeout !== 1'b1) begin
      failures++;
      $display("[TB] FAIL timeout_err got %b expected 1", err_timeout);
    end
`else
    checks++;
    if (eng_busy !== 3'b111) begin
      failures++;
      $display("[TB] FAIL timeout_busy got %b expected 111", eng_busy);
    end
    checks++;
    if (err_timeout !== 1'b0) begin
      failures++;
      $display("[TB] FAIL timeout_err got %b expected 0", err_timeout);
    end
`endif
  endtask

  // Asynchronous reset mid-stream clears everything and issues no eof
  task automatic test_reset_midstream();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
    push(EV_ROI, 3'b001, 16'hF000);
    push(EV_HIT, 3'b001, 16'h5000);
    push(EV_HIT, 3'b001, 16'h5001);
    drive(1'b1, 16'hF000, 1'b0, 16'h0, 1'b0, 3'b000);
    drive(1'b0, 16'h0, 1'b1, 16'h5000, 1'b0, 3'b000);
    drive(1'b0, 16'h0, 1'b1, 16'h5001, 1'b0, 3'b000);
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 3'b000);
    checks++;
    if (eng_busy !== 3'b001 || err_timeout !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midstream_busy got busy=%b err=%b expected 001/0", eng_busy, err_timeout);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (eng_hit_we !== 3'b000 || eng_busy !== 3'b000 || eng_hit !== 16'h0 || eng_roi !== 16'h0) begin
      failures++;
      $display("[TB] FAIL midstream_async got hit_we=%b busy=%b hit=%h roi=%h expected all 0",
               eng_hit_we, eng_busy, eng_hit, eng_roi);
    end
    idle(2);
    reset = 1'b0;
    idle(4);
    checks++;
    if (drop_count !== 16'd0) begin
      failures++;
      $display("[TB] FAIL midstream_count got %0d expected 0", drop_count);
    end
    push(EV_ROI, 3'b001, 16'hF001);
    push(EV_HIT, 3'b001, 16'h5100);
    push(EV_EOF, 3'b001, 16'h0);
    drive(1'b1, 16'hF001, 1'b0, 16'h0, 1'b0, 3'b000);
    drive(1'b0, 16'h0, 1'b1, 16'h5100, 1'b1, 3'b000);
    idle(3);
  endtask

  initial begin
    $display("[TB] lsf_engine_scheduler bench start");
    test_reset();
    test_basic();
    test_drop();
    test_done_same_cycle();
    test_cap();
    test_roi_in_stream();
    test_timeout();
    test_reset_midstream();
    for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL missing_events got %0d outstanding expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsf_engine_scheduler.md
Name: lsf_engine_scheduler

Overview:
- Sits between the hit-extraction outputs (one ROI/SLC word followed by its MDT hit train) and a bank of NUM_ENGINES Legendre segment-finder engines.
- Assigns each incoming ROI to a free engine in round-robin order, then steers that ROI's hits to the chosen engine.
- Closes each event with a one-cycle eof pulse and tracks engine busy state until the engine reports its result.
- Drops and counts ROIs that arrive while every engine is busy.

Parameters:
- NUM_ENGINES, 3, number of engine slots; legal range 1..8.
- ROI_W, HEG2SFSLC_LEN, ROI word width.
- HIT_W, HEG2SFHIT_LEN, hit word width.
- MAX_HITS, 32, hit-count cap per ROI; forces close when reached.
- TIMEOUT, 1024, busy watchdog limit in cycles; used only with the optional feature.

Ports:
- clock  in  1  single clock domain.
- reset  in  1  asynchronous, active-high.
- roi  in  ROI_W  ROI word.
- roi_we  in  1  ROI valid, single-cycle.
- mdt_hit  in  HIT_W  hit word.
- mdt_hit_we  in  1  hit valid.
- hits_last  in  1  marks the final hit of the current ROI; qualified by mdt_hit_we.
- eng_done  in  NUM_ENGINES  per-engine result-valid pulse (le_output_vld).
- eng_roi  out  ROI_W  registered ROI, broadcast to all engines.
- eng_roi_we  out  NUM_ENGINES  one-hot ROI write.
- eng_hit  out  HIT_W  registered hit, broadcast.
- eng_hit_we  out  NUM_ENGINES  one-hot hit write.
- eng_eof  out  NUM_ENGINES  one-hot end-of-event pulse.
- eng_busy  out  NUM_ENGINES  busy flags.
- roi_drop  out  1  pulse when an ROI is dropped.
- drop_count  out  16  saturating drop counter.
- err_timeout  out  1  sticky watchdog flag; tied 0 when the optional feature is compiled out.

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; round-robin pointer = 0; hit counter = 0.
- Latency: every eng_* data/strobe output is registered, 1 cycle after its input.
- Engine selection: search begins at the pointer and wraps modulo NUM_ENGINES; the first engine with busy=0 wins. After an assignment, pointer = winner+1 (wrapping).
- eng_done[i] clears busy[i] on the following edge. A done and a new assignment in the same cycle: done is evaluated first, so an engine freed in cycle N is selectable by an ROI arriving in cycle N.
- FSM states and transitions:
  - IDLE:
    - roi_we with a free engine: latch the selection, pulse eng_roi_we[sel], set busy[sel], clear the hit counter, go to STREAM.
    - roi_we with no free engine: pulse roi_drop, increment drop_count (holds at 0xFFFF), go to DISCARD.
    - mdt_hit_we in IDLE: hit is ignored.
  - STREAM:
    - each mdt_hit_we forwards the hit to eng_hit_we[sel] and increments the counter.
    - hits_last, or the counter reaching MAX_HITS: go to CLOSE. With hits_last asserted, that final hit is still forwarded.
    - hits beyond MAX_HITS, up to hits_last, are discarded (go to DISCARD when the cap is hit without hits_last).
  - CLOSE: pulse eng_eof[sel] for exactly 1 cycle, then go to IDLE.
  - DISCARD: swallow hits; on hits_last, go to IDLE.
- roi_we in STREAM: forces CLOSE for the current engine. The new ROI is held in a 1-deep pending register and serviced in IDLE on the next cycle, as though it had arrived then.
- roi_we in CLOSE or DISCARD: same pending-register handling. A second roi_we while the pending register is full is dropped and counted.
- eng_done on an engine that is not busy: ignored.
- Reset mid-stream: all state clears immediately and asynchronously; no eof is issued.

Optional Feature:
- Macro: LSF_SCHED_TIMEOUT_EN.
- Compiled in: a per-engine counter runs while busy. On reaching TIMEOUT without eng_done, that engine's busy is cleared, err_timeout is set (sticky until reset) and the engine becomes selectable again.
- Compiled out: no counters; err_timeout is tied 0; an engine stays busy until eng_done.

Test Plan:
- NUM_ENGINES=3; 3 ROIs each with 4 hits, no done -> ROIs go to engines 0,1,2; each gets 4 eng_hit_we and 1 eng_eof; eng_busy=3'b111.
- Fourth ROI with all engines busy -> roi_drop pulse; drop_count=1; its 4 hits produce no eng_hit_we.
- eng_done[1] in the same cycle as roi_we -> ROI assigned to engine 1; busy[1] stays 1; pointer=2.
- 40 hits, no hits_last -> exactly 32 eng_hit_we, eof after the 32nd; remaining 8 swallowed until hits_last.
- roi_we during STREAM -> current engine gets eof; new ROI goes to the next free engine 2 cycles later.
- With LSF_SCHED_TIMEOUT_EN, TIMEOUT=16 and no done -> busy clears at 16 cycles; err_timeout=1 until reset.
